// File: rtl/mem_pkt_receiver.sv
// Memory-pipe receive buffer: queues AGEN packets in order and hands them to
// the LSQ/D-cache port one per cycle, with early issue backpressure and flush.

package memPktReceiverPkg;

    typedef struct packed {
        logic        valid;
        logic [7:0]  seqNo;
        logic [31:0] pc;
        logic [3:0]  flags;
        logic [1:0]  ldstSize;   // 0 byte, 1 half, 2 word, 3 double
        logic [6:0]  phyDest;
        logic [31:0] address;
        logic [63:0] src2Data;
        logic [4:0]  lsqID;
        logic [6:0]  alID;
    } memPkt;

endpackage

module mem_pkt_receiver
    import memPktReceiverPkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int STALL_SLACK = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  memPkt                      memPacket_i,
    input  logic                       recoverFlag_i,
    input  logic                       dcReady_i,
    output memPkt                      memPacket_o,
    output logic                       misaligned_o,
    output logic                       stall_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overflow_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Handshake: the head packet transfers on a rising edge where
    // memPacket_o.valid && dcReady_i (and no recovery); the head holds
    // steady until then, and memPacket_o never depends on dcReady_i.

    memPkt          entry [DEPTH];
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic [CW-1:0]  count;
    logic           overflow;

    logic push;
    logic pop;
    logic full;
    logic wrEn;
    logic drop;

    assign push = memPacket_i.valid && !recoverFlag_i;
    assign pop  = (count != '0) && dcReady_i && !recoverFlag_i;
    assign full = (count == CW'(DEPTH));
    assign wrEn = push && (!full || pop);
    assign drop = push && full && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (recoverFlag_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wrEn) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            if (wrEn && !pop)
                count <= count + CW'(1);
            else if (pop && !wrEn)
                count <= count - CW'(1);
            if (drop) overflow <= 1'b1;
        end
    end

    // Storage is deliberately left unreset; only the pointers define contents.
    always_ff @(posedge clk) begin
        if (!reset && wrEn) entry[tail] <= memPacket_i;
    end

    logic [2:0] alignMask;

    always_comb begin
        memPacket_o       = entry[head];
        memPacket_o.valid = (count != '0);
    end

    always_comb begin
        alignMask = 3'b000;
        case (memPacket_o.ldstSize)
            2'd0:    alignMask = 3'b000;
            2'd1:    alignMask = 3'b001;
            2'd2:    alignMask = 3'b011;
            default: alignMask = 3'b111;
        endcase
    end

    assign misaligned_o = memPacket_o.valid && ((memPacket_o.address[2:0] & alignMask) != 3'b000);
    assign stall_o      = (count >= CW'(DEPTH - STALL_SLACK));
    assign count_o      = count;
    assign overflow_o   = overflow;

endmodule
